sw_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the board logic's 16-bit `sw` bus.
- Takes raw, asynchronous, bouncy slide-switch levels and synchronises each bit into the clock domain.
- Debounces each bit by periodic sampling and delivers a clean `sw_out` bus to the downstream logic.
- Also emits one-cycle rise/fall strobes per bit, plus an aggregate change strobe.

---
 rtl/sw_debounce_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 80 ++++++++
 rtl/sw_debounce.sv | 70 +++++++
 tb/tb_sw_debounce.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_debounce_pkg;

    localparam int WIDTH       = 16;      // switch bits
    localparam int TICK_DIV    = 100000;  // clock cycles per sample tick
    localparam int STABLE_CNT  = 4;       // disagreeing samples needed to accept a level
    localparam int SYNC_STAGES = 2;       // synchroniser depth

    // Counter width able to hold 0..stable_cnt; never narrower than one bit.
    function automatic int cnt_width(input int stable_cnt);
        int w;
        w = $clog2(stable_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Prescaler width able to hold 0..tick_div-1.
    function automatic int div_width(input int tick_div);
        int w;
        w = $clog2(tick_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, level register
// and registered rise/fall strobes. Advances only on the shared tick.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CNT_P = STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic strobe_next
);

    localparam int CW = cnt_width(STABLE_CNT_P);
    // Counter value at which the next disagreeing sample accepts the new level.
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT_P - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain every cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    end

    // On a tick: agreement clears the counter, disagreement counts up and
    // flips the level once STABLE_CNT_P consecutive samples have disagreed.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (sync_bit == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    // Lets the top register an aggregate strobe aligned with rise/fall.
    assign strobe_next = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch input conditioner: shared sample prescaler, WIDTH independent
// debounce_bit slices and a registered aggregate change strobe.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH      = sw_debounce_pkg::WIDTH,
    parameter int TICK_DIV   = sw_debounce_pkg::TICK_DIV,
    parameter int STABLE_CNT = sw_debounce_pkg::STABLE_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam int PW = div_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] strobe_next;

    // Prescaler wraps at TICK_DIV-1; tick is registered off the terminal count.
    always_comb begin
        pre_d  = (pre_q == DIV_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_q == DIV_LAST);
    end

    // Any bit about to strobe raises the aggregate change pulse.
    always_comb begin
        changed_d = |strobe_next;
    end

    // Prescaler, tick and change strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            tick_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            changed_q <= changed_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CNT_P(STABLE_CNT)
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_q),
            .raw        (sw_raw[i]),
            .level      (sw_out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .strobe_next(strobe_next[i])
        );
    end

    assign tick    = tick_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: stimulus pushes expected outputs from a sample-history
// reference model into a queue; a negedge monitor pops and compares.
module tb_sw_debounce;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int EW = 3 * W + 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out, rise, fall;
  logic         changed, tick;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed),
    .tick   (tick)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  // Inputs seen since reset release, the per-tick samples taken from them,
  // and per bit the sample index at which its history restarted (last flip).
  logic [W-1:0] m_out;
  int           edge_n;
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] samples[$];
  int           since[W];

  task automatic model_edge(input logic [W-1:0] raw, input logic r);
    logic [W-1:0] rise_e, fall_e, smp;
    logic         tick_e;
    int           n;
    bit           all_diff;
    rise_e = '0;
    fall_e = '0;
    tick_e = 1'b0;
    if (r) begin
      edge_n = 0;
      m_out  = '0;
      raw_hist.delete();
      samples.delete();
      for (int i = 0; i < W; i++) since[i] = 0;
    end else begin
      edge_n++;
      raw_hist.push_back(raw);
      // Samples are taken on edges TD+1, 2TD+1, ... and see the pin value
      // captured two edges earlier (synchroniser delay).
      if (edge_n > TD && (edge_n - 1) % TD == 0) begin
        smp = (edge_n >= 3) ? raw_hist[edge_n - 3] : '0;
        samples.push_back(smp);
        n = samples.size();
        for (int i = 0; i < W; i++) begin
          if (n - since[i] >= SC) begin
            all_diff = 1'b1;
            for (int k = n - SC; k < n; k++)
              if (samples[k][i] == m_out[i]) all_diff = 1'b0;
            if (all_diff) begin
              if (m_out[i]) fall_e[i] = 1'b1;
              else          rise_e[i] = 1'b1;
              m_out[i] = ~m_out[i];
              since[i] = n;
            end
          end
        end
      end
      tick_e = (edge_n % TD == 0);
    end
    exp_q.push_back({tick_e, |(rise_e | fall_e), fall_e, rise_e, m_out});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] raw, input logic r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sw_raw = raw;
      rst    = r;
      @(posedge clk);
      model_edge(raw, r);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tick, changed, fall, rise, sw_out};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got tick=%b chg=%b fall=%h rise=%h out=%h exp tick=%b chg=%b fall=%h rise=%h out=%h",
                 cyc, a[EW-1], a[EW-2], a[3*W-1:2*W], a[2*W-1:W], a[W-1:0],
                 e[EW-1], e[EW-2], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] cur;
    // 1. reset with all switches high, then power-up debounce to FFFF
    drive(16'hFFFF, 1'b1, 5);
    drive(16'hFFFF, 1'b0, 25);
    // all bits fall back to zero
    drive(16'h0000, 1'b0, 25);
    // 2. clean toggle of bit 3
    drive(16'h0008, 1'b0, 25);
    // 3. bit 0 high across exactly two sample points
    drive(16'h0009, 1'b0, 8);
    drive(16'h0008, 1'b0, 20);
    // 4. release bit 3
    drive(16'h0000, 1'b0, 25);
    // 5. bits 1, 7, 15 together
    drive(16'h8082, 1'b0, 25);
    // 6. bit 5 mid-debounce, then reset
    drive(16'h80A2, 1'b0, 10);
    drive(16'h80A2, 1'b1, 2);
    drive(16'h80A2, 1'b0, 30);
    // 7. randomized bouncing with occasional resets
    cur = 16'h80A2;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 39) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 599) == 0) drive(cur, 1'b1, 2);
      else                             drive(cur, 1'b0, 1);
    end
    drive(cur, 1'b0, 20);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
